// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle: raw slot sensors in, clean coin events and status out.
// insert is a one-cycle strobe; coins carries the coin code only while insert=1 and is 00 otherwise.
interface coin_acceptor_if #(
  parameter int COUNT_W = 8
);
  logic               slot_c1;
  logic               slot_c2;
  logic               insert;
  logic [1:0]         coins;
  logic               jam;
  logic [COUNT_W-1:0] coin_count;
  logic [2:0]         state;

  modport master (
    input  slot_c1, slot_c2,
    output insert, coins, jam, coin_count, state
  );

  modport slave (
    output slot_c1, slot_c2,
    input  insert, coins, jam, coin_count, state
  );
endinterface

// File: rtl/coin_acceptor.sv
// Synchronizes, debounces and classifies two bouncy coin-slot sensors into one clean
// insert strobe per coin, with jam detection and a saturating accepted-coin count.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int COUNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  coin_acceptor_if.master  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] QUAL    = 3'd1;
  localparam logic [2:0] EMIT    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] JAM     = 3'd4;

  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = DEBOUNCE - 1;
  localparam logic [CNT_W-1:0]   CNT_FULL  = DEBOUNCE;
  localparam logic [COUNT_W-1:0] COUNT_ONE = 1;

  logic [1:0]         c1_sync;
  logic [1:0]         c2_sync;
  logic [1:0]         s;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cand_q, cand_d;
  logic               insert_q;
  logic [1:0]         coins_q;
  logic               jam_q;
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c1_sync <= 2'b00;
      c2_sync <= 2'b00;
    end else begin
      c1_sync <= {c1_sync[0], bus.slot_c1};
      c2_sync <= {c2_sync[0], bus.slot_c2};
    end
  end

  assign s = {c2_sync[1], c1_sync[1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (s == 2'b01 || s == 2'b10) begin
          cand_d  = s;
          cnt_d   = CNT_ONE;
          state_d = QUAL;
        end else if (s == 2'b11) begin
          cnt_d   = '0;
          state_d = JAM;
        end
      end
      QUAL: begin
        if (s == 2'b11) begin
          cnt_d   = '0;
          state_d = JAM;
        end else if (s == 2'b00) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s == cand_q) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE == CNT_FULL) state_d = EMIT;
        end else begin
          // Other single coin took over: requalify from scratch.
          cand_d = s;
          cnt_d  = CNT_ONE;
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE, JAM: begin
        if (s == 2'b00) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
          if (s == 2'b11) state_d = JAM;
        end
      end
      default: begin
        cnt_d   = '0;
        cand_d  = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered off the next state so insert lines up with the EMIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= 2'b00;
      insert_q <= 1'b0;
      coins_q  <= 2'b00;
      jam_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      insert_q <= (state_d == EMIT);
      coins_q  <= (state_d == EMIT) ? cand_d : 2'b00;
      jam_q    <= (state_d == JAM);
      if (state_d == EMIT && count_q != '1) count_q <= count_q + COUNT_ONE;
    end
  end

  assign bus.insert     = insert_q;
  assign bus.coins      = coins_q;
  assign bus.jam        = jam_q;
  assign bus.coin_count = count_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a main instance (8-bit count) and a 2-bit-count instance
// share the stimulus; every strobe is checked against a queue of expected {coins, count}.
module tb_coin_acceptor;

  logic clk;
  logic reset;
  logic slot_c1;
  logic slot_c2;

  int checks;
  int errors;

  logic [9:0] exp_q[$];
  logic [3:0] exp_sat_q[$];
  logic [7:0] model_cnt;
  logic [1:0] model_sat;

  coin_acceptor_if #(.COUNT_W(8)) bus ();
  coin_acceptor_if #(.COUNT_W(2)) bus_sat ();

  assign bus.slot_c1     = slot_c1;
  assign bus.slot_c2     = slot_c2;
  assign bus_sat.slot_c1 = slot_c1;
  assign bus_sat.slot_c2 = slot_c2;

  coin_acceptor #(.DEBOUNCE(4), .COUNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  coin_acceptor #(.DEBOUNCE(4), .COUNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_sat.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_coin(input logic [1:0] code);
    model_cnt = model_cnt + 8'd1;
    if (model_sat != 2'b11) model_sat = model_sat + 2'd1;
    exp_q.push_back({code, model_cnt});
    exp_sat_q.push_back({code, model_sat});
  endtask

  task automatic clean_coin(input logic [1:0] code, input int hold);
    @(negedge clk);
    expect_coin(code);
    slot_c1 = code[0];
    slot_c2 = code[1];
    ticks(hold);
    slot_c1 = 1'b0;
    slot_c2 = 1'b0;
    ticks(10);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_cnt = '0;
    model_sat = '0;
    ticks(2);
    chk("reset_state", {29'd0, bus.state}, 32'd0);
    chk("reset_outs", {bus.insert, bus.coins, bus.jam, bus.coin_count}, 32'd0);
    chk("reset_sat_count", {30'd0, bus_sat.coin_count}, 32'd0);
    reset = 1'b1;
  endtask

  // scoreboard monitor, one pass per negedge
  task automatic monitor_cycle();
    logic [9:0] e;
    logic [3:0] es;
    if (bus.insert) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got coins=%b count=%0d expected no strobe", bus.coins, bus.coin_count);
      end else begin
        e = exp_q.pop_front();
        if ({bus.coins, bus.coin_count} !== e) begin
          errors++;
          $display("FAIL strobe: got coins=%b count=%0d expected coins=%b count=%0d",
                   bus.coins, bus.coin_count, e[9:8], e[7:0]);
        end
      end
    end else if (bus.coins !== 2'b00) begin
      checks++;
      errors++;
      $display("FAIL coins_idle: got %b expected 00", bus.coins);
    end
    if (bus_sat.insert) begin
      checks++;
      if (exp_sat_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sat_strobe: got coins=%b count=%0d expected no strobe",
                 bus_sat.coins, bus_sat.coin_count);
      end else begin
        es = exp_sat_q.pop_front();
        if ({bus_sat.coins, bus_sat.coin_count} !== es) begin
          errors++;
          $display("FAIL sat_strobe: got coins=%b count=%0d expected coins=%b count=%0d",
                   bus_sat.coins, bus_sat.coin_count, es[3:2], es[1:0]);
        end
      end
    end
  endtask

  task automatic run_tests();
    do_reset();

    // clean 1-unit coin with exact latency
    @(negedge clk);
    expect_coin(2'b01);
    slot_c1 = 1'b1;
    ticks(5);
    chk("latency_before", {31'd0, bus.insert}, 32'd0);
    ticks(1);
    chk("latency_at", {31'd0, bus.insert}, 32'd1);
    chk("emit_state", {29'd0, bus.state}, 32'd2);
    ticks(4);
    slot_c1 = 1'b0;
    ticks(10);
    chk("clean_state", {29'd0, bus.state}, 32'd0);
    chk("clean_count", {24'd0, bus.coin_count}, 32'd1);

    // bouncing 2-unit coin
    @(negedge clk);
    expect_coin(2'b10);
    for (int i = 0; i < 4; i++) begin
      slot_c2 = (i % 2 == 0);
      ticks(1);
    end
    slot_c2 = 1'b1;
    ticks(8);
    slot_c2 = 1'b0;
    ticks(10);
    chk("bounce_count", {24'd0, bus.coin_count}, 32'd2);

    // glitch reject
    @(negedge clk);
    slot_c1 = 1'b1;
    ticks(2);
    slot_c1 = 1'b0;
    ticks(1);
    chk("glitch_qual", {29'd0, bus.state}, 32'd1);
    ticks(8);
    chk("glitch_idle", {29'd0, bus.state}, 32'd0);
    chk("glitch_count", {24'd0, bus.coin_count}, 32'd2);

    // jam, then recovery and a normal coin
    @(negedge clk);
    slot_c1 = 1'b1;
    slot_c2 = 1'b1;
    ticks(3);
    chk("jam_flag", {31'd0, bus.jam}, 32'd1);
    chk("jam_state", {29'd0, bus.state}, 32'd4);
    ticks(3);
    slot_c1 = 1'b0;
    slot_c2 = 1'b0;
    ticks(10);
    chk("jam_clear", {31'd0, bus.jam}, 32'd0);
    chk("jam_idle", {29'd0, bus.state}, 32'd0);
    clean_coin(2'b01, 8);
    chk("after_jam_count", {24'd0, bus.coin_count}, 32'd3);

    // saturation: 2-bit counter reads 1,2,3,3,3 over five coins
    do_reset();
    clean_coin(2'b01, 8);
    chk("sat_1", {30'd0, bus_sat.coin_count}, 32'd1);
    clean_coin(2'b10, 8);
    chk("sat_2", {30'd0, bus_sat.coin_count}, 32'd2);
    clean_coin(2'b01, 8);
    chk("sat_3", {30'd0, bus_sat.coin_count}, 32'd3);
    clean_coin(2'b10, 8);
    chk("sat_4", {30'd0, bus_sat.coin_count}, 32'd3);
    clean_coin(2'b01, 8);
    chk("sat_5", {30'd0, bus_sat.coin_count}, 32'd3);
    chk("sat_main_count", {24'd0, bus.coin_count}, 32'd5);

    // async reset while qualifying
    @(negedge clk);
    slot_c1 = 1'b1;
    ticks(3);
    chk("pre_reset_qual", {29'd0, bus.state}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", {29'd0, bus.state}, 32'd0);
    chk("async_outs", {bus.insert, bus.coins, bus.jam, bus.coin_count}, 32'd0);
    slot_c1 = 1'b0;
    model_cnt = '0;
    model_sat = '0;
    ticks(2);
    reset = 1'b1;
    ticks(15);
    chk("post_reset_state", {29'd0, bus.state}, 32'd0);
    chk("post_reset_count", {24'd0, bus.coin_count}, 32'd0);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exp_sat_q_drained", exp_sat_q.size(), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    slot_c1   = 1'b0;
    slot_c2   = 1'b0;
    model_cnt = '0;
    model_sat = '0;
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
      run_tests();
    join_any
    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
